// File: rtl/transmitter1.sv
// ---------------------------------------------------------------------------
// transmitter1 - single-wire byte serialiser, one bit per clk.
//
// Frame on tx: idle high, one low start cycle, 8 data bits LSB first, then
// STOP_CYCLES high stop cycles. done pulses in the last stop cycle.
//
// Parameters:
//   STOP_CYCLES  number of high stop cycles after bit 7 (1..15)
//
// Optional feature (macro TX_HOLD_BUF_EN):
//   adds a one-entry holding buffer so a byte can be accepted while a frame
//   is in flight; it is chained onto the line with no idle cycle.
//   Undefined (default): at most one byte is owned by the block.
//
// Ports:
//   clk       system clock, all logic on posedge
//   srst_n    synchronous active-low reset
//   in_valid  in_data holds a byte to send
//   in_ready  block can accept a byte this cycle (combinational)
//   in_data   byte to transmit, bit 0 first
//   tx        serial line, registered, idle high
//   busy      frame in progress (start, data or stop phase)
//   done      one-cycle pulse in the last stop cycle of each frame
// ---------------------------------------------------------------------------
module transmitter1 #(
    parameter int unsigned STOP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       srst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STOP_W = 4;

    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_CYCLES);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);

    // Reject illegal stop lengths at elaboration.
    if (STOP_CYCLES == 0 || STOP_CYCLES > 15) begin : g_bad_stop_cycles
        $error("transmitter1: STOP_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nxt;
    logic [STOP_W-1:0]   stop_cnt;
    logic [STOP_W-1:0]   stop_cnt_nxt;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shift_nxt;
    logic                tx_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    logic                xfer;
    logic                last_stop;
    logic                start_frame;
    logic [DATA_W-1:0]   start_data;

`ifdef TX_HOLD_BUF_EN
    logic                buf_valid;
    logic                buf_valid_nxt;
    logic [DATA_W-1:0]   buf_data;
    logic [DATA_W-1:0]   buf_data_nxt;

    // Ready whenever the holding slot is free; never during reset.
    assign in_ready = !buf_valid && srst_n;
`else
    // Only one byte in flight: accept in IDLE only; never during reset.
    assign in_ready = (state == IDLE) && srst_n;
`endif

    assign xfer      = in_valid && in_ready;
    assign last_stop = (state == STOP) && (stop_cnt == STOP_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shift_nxt    = shift;
        tx_nxt       = tx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        start_frame  = 1'b0;
        start_data   = in_data;
`ifdef TX_HOLD_BUF_EN
        buf_valid_nxt = buf_valid;
        buf_data_nxt  = buf_data;
`endif

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (xfer) begin
                    start_frame = 1'b1;
                end
            end

            START: begin
                state_nxt   = DATA;
                tx_nxt      = shift[0];
                shift_nxt   = shift >> 1;
                bit_cnt_nxt = '0;
            end

            DATA: begin
                // Counter wraps to 0 after bit 7.
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                if (bit_cnt == BIT_LAST) begin
                    state_nxt    = STOP;
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = STOP_W'(1);
                    done_nxt     = (STOP_LAST == STOP_W'(1));
                end else begin
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                end
            end

            STOP: begin
                if (last_stop) begin
                    state_nxt    = IDLE;
                    tx_nxt       = 1'b1;
                    busy_nxt     = 1'b0;
                    stop_cnt_nxt = '0;
`ifdef TX_HOLD_BUF_EN
                    // Chain the next frame with no idle cycle.
                    if (buf_valid) begin
                        start_frame   = 1'b1;
                        start_data    = buf_data;
                        buf_valid_nxt = 1'b0;
                    end else if (xfer) begin
                        start_frame = 1'b1;
                    end
`endif
                end else begin
                    stop_cnt_nxt = stop_cnt + STOP_W'(1);
                    done_nxt     = ((stop_cnt + STOP_W'(1)) == STOP_LAST);
                end
            end

            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

`ifdef TX_HOLD_BUF_EN
        // A byte accepted while a frame is running waits in the buffer.
        if (xfer && !start_frame) begin
            buf_valid_nxt = 1'b1;
            buf_data_nxt  = in_data;
        end
`endif

        // Launch a frame: start bit goes out next cycle.
        if (start_frame) begin
            state_nxt    = START;
            tx_nxt       = 1'b0;
            busy_nxt     = 1'b1;
            done_nxt     = 1'b0;
            shift_nxt    = start_data;
            bit_cnt_nxt  = '0;
            stop_cnt_nxt = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

`ifdef TX_HOLD_BUF_EN
    // Holding buffer registers.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            buf_valid <= buf_valid_nxt;
            buf_data  <= buf_data_nxt;
        end
    end
`endif

endmodule
